ps2_matrix_scan: RTL

Parametrised PS/2-to-key-matrix converter. Sits between the PS/2 receiver and the PPI keyboard port. Incoming scan-code events are buffered in a FIFO so none are dropped while a translation is in progress. Each event is translated through an external keymap ROM into a ROWS×COLS pressed-key matrix held in flops, and the matrix row selected by the PPI is returned as active-low columns, with a shift key that software can override per key.

---
 rtl/ps2_matrix_scan.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/ps2_matrix_scan.sv
// PS/2 scan-code events to a ROWS x COLS key matrix read by the PPI.
// Define KBD_FKEY_TOGGLE_EN to turn F9-F12/PgUp/PgDn makes into f_keys toggles.
module ps2_matrix_scan #(
  parameter int ROWS       = 11,
  parameter int COLS       = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int SHIFT_ROW  = 6,
  parameter int SHIFT_COL  = 0,
  localparam int ROW_W = $clog2(ROWS),
  localparam int COL_W = $clog2(COLS),
  localparam int MAP_W = 3 + ROW_W + COL_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clk_ena,
  input  logic [10:0]     ps2_key,
  input  logic            release_all,
  input  logic [3:0]      row_sel,
  output logic [COLS-1:0] col_n,
  output logic [9:0]      map_addr,
  input  logic [MAP_W-1:0] map_data,
  output logic [5:0]      f_keys,
  output logic            overflow,
  output logic            busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE, LOOK0, APPLY0, LOOK1, APPLY1
  } state_t;

  state_t state, state_n;

  logic [9:0]       fifo [FIFO_DEPTH];
  logic [PTR_W:0]   wr_ptr, rd_ptr;
  logic             empty, full;
  logic             strobe, pop_ok, ovf_evt, flush, push;
  logic [9:0]       head;
  logic             h_brk, h_ext, is_shift_h, fk_hit;
  logic [7:0]       h_code;

  logic [9:0]       cur;
  logic             phys_shift;
  logic             ovr_act, ovr_val;
  logic [8:0]       owner;
  logic [ROWS-1:0][COLS-1:0] cells, eff;
  logic [COLS-1:0]  sel_n;

  logic             m_valid, m_force, m_vsval, in_range;
  logic [ROW_W-1:0] m_row;
  logic [COL_W-1:0] m_col;
  logic             apply, cell_we, ovr_set, ovr_clr;
  logic             addr_ld0, addr_ld1;

  assign strobe = ps2_key[10];
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                  (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign head   = fifo[rd_ptr[PTR_W-1:0]];
  assign h_brk  = head[9];
  assign h_ext  = head[8];
  assign h_code = head[7:0];
  assign is_shift_h = !h_ext && (h_code == 8'h12 || h_code == 8'h59);

  // A pop in the same cycle frees a slot, so a full FIFO only overflows without one.
  assign pop_ok  = (state == IDLE) && clk_ena && !empty && !release_all;
  assign ovf_evt = strobe && full && !pop_ok && !release_all;
  assign flush   = release_all || ovf_evt;
  assign push    = strobe && !flush;
  assign busy    = !empty || (state != IDLE);

  assign m_valid = map_data[MAP_W-1];
  assign m_force = map_data[MAP_W-2];
  assign m_vsval = map_data[MAP_W-3];
  assign m_row   = map_data[ROW_W+COL_W-1:COL_W];
  assign m_col   = map_data[COL_W-1:0];
  assign in_range = (int'(m_row) < ROWS) && (int'(m_col) < COLS);

`ifdef KBD_FKEY_TOGGLE_EN
  logic [5:0] fk_vec, fk_q;

  assign fk_vec = {
    h_ext  && h_code == 8'h7D,
    h_ext  && h_code == 8'h7A,
    !h_ext && h_code == 8'h01,
    !h_ext && h_code == 8'h09,
    !h_ext && h_code == 8'h78,
    !h_ext && h_code == 8'h07
  };
  assign fk_hit = |fk_vec;
  assign f_keys = fk_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      fk_q <= '0;
    else if (pop_ok && !h_brk)
      fk_q <= fk_q ^ fk_vec;
  end
`else
  assign fk_hit = 1'b0;
  assign f_keys = '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      fifo[wr_ptr[PTR_W-1:0]] <= ps2_key[9:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (clk_ena) begin
      unique case (state)
        IDLE:    if (pop_ok && !fk_hit) state_n = LOOK0;
        LOOK0:   state_n = APPLY0;
        APPLY0:  state_n = cur[9] ? LOOK1 : IDLE;
        LOOK1:   state_n = APPLY1;
        APPLY1:  state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
    if (flush) state_n = IDLE;
  end

  always_comb begin
    apply    = 1'b0;
    cell_we  = 1'b0;
    ovr_set  = 1'b0;
    ovr_clr  = 1'b0;
    addr_ld0 = 1'b0;
    addr_ld1 = 1'b0;
    if (clk_ena && !flush) begin
      apply    = (state == APPLY0) || (state == APPLY1);
      cell_we  = apply && m_valid && in_range;
      ovr_set  = (state == APPLY0) && !cur[9] && m_valid && m_force;
      ovr_clr  = (state == APPLY0) && cur[9] && ovr_act &&
                 (cur[8:0] == owner);
      addr_ld0 = pop_ok && !fk_hit;
      addr_ld1 = (state == APPLY0) && cur[9];
    end
  end

  always_comb begin
    eff = cells;
    eff[SHIFT_ROW][SHIFT_COL] = ovr_act ? ovr_val :
      (phys_shift | cells[SHIFT_ROW][SHIFT_COL]);
    sel_n = '1;
    for (int r = 0; r < ROWS; r++)
      if (int'(row_sel) == r) sel_n = ~eff[r];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur        <= '0;
      map_addr   <= '0;
      phys_shift <= 1'b0;
      cells      <= '0;
      ovr_act    <= 1'b0;
      ovr_val    <= 1'b0;
      owner      <= '0;
      overflow   <= 1'b0;
      col_n      <= '1;
    end else begin
      overflow <= ovf_evt;
      col_n    <= sel_n;
      if (flush) begin
        cells      <= '0;
        phys_shift <= 1'b0;
        ovr_act    <= 1'b0;
      end else begin
        if (pop_ok) begin
          cur <= head;
          if (is_shift_h) phys_shift <= !h_brk;
        end
        // Breaks look up the unshifted entry first, then the shifted one.
        if (addr_ld0)
          map_addr <= {!h_brk && (is_shift_h || phys_shift), h_ext, h_code};
        if (addr_ld1)
          map_addr <= {1'b1, cur[8:0]};
        if (cell_we)
          cells[m_row][m_col] <= !cur[9];
        if (ovr_set) begin
          ovr_act <= 1'b1;
          ovr_val <= m_vsval;
          owner   <= cur[8:0];
        end
        if (ovr_clr)
          ovr_act <= 1'b0;
      end
    end
  end

endmodule
